// File: rtl/ihex_encoder_if.sv
// ROM read port and ASCII transmit stream of the Intel HEX encoder.
// The master side issues ROM reads and sources characters. The slave side returns ROM bytes and sinks characters.
interface ihex_encoder_if #(
    parameter int ADDR_W = 15
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_rd, mem_addr, tx_data, tx_valid,
        input  mem_data, tx_ready
    );

    modport slave (
        input  mem_rd, mem_addr, tx_data, tx_valid,
        output mem_data, tx_ready
    );
endinterface

// File: rtl/ihex_encoder.sv
// Dumps ROM[0..length-1] as Intel HEX text (data records + EOF), one char per beat; ':' appears the cycle after start.
// Character states hold tx_valid/tx_data until tx_ready; each data byte costs FETCH+WAIT+2 chars.
module ihex_encoder #(
    parameter int ADDR_W  = 15,
    parameter int REC_LEN = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] length,
    output logic            busy,
    output logic            done,
    ihex_encoder_if.master  bus
);
    typedef enum logic [4:0] {
        S_IDLE, S_COLON, S_LEN_H, S_LEN_L, S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0,
        S_TYPE_H, S_TYPE_L, S_FETCH, S_WAIT, S_DATA_H, S_DATA_L,
        S_CSUM_H, S_CSUM_L, S_CR, S_LF, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(REC_LEN);
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W:0]   r_addr;
    logic [7:0]        r_rec_len;
    logic [7:0]        r_rec_cnt;
    logic [15:0]       r_rec_addr;
    logic [7:0]        r_csum;
    logic [3:0]        r_lo;
    logic              r_type;
    logic              r_eof_sent;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W:0]   w_len_sat;
    logic [ADDR_W:0]   w_src_rem;
    logic [ADDR_W:0]   w_src_addr;
    logic [7:0]        w_ll;
    logic [15:0]       w_addr16;
    logic [7:0]        w_hdr_sum;
    logic [7:0]        w_cc;
    logic              w_finish;
    logic              w_new_rec;

    function automatic logic [7:0] hex(input logic [3:0] n);
        hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Record setup reads the fresh length in IDLE, the running counters after LF.
    always_comb begin
        w_len_sat  = length[ADDR_W] ? FULL : length;
        w_src_rem  = (r_state == S_IDLE) ? w_len_sat : r_rem;
        w_src_addr = (r_state == S_IDLE) ? '0 : r_addr;
        w_ll       = (w_src_rem > LIM) ? 8'(REC_LEN) : 8'(w_src_rem);
        w_addr16   = 16'(w_src_addr);
        w_hdr_sum  = w_ll + w_addr16[15:8] + w_addr16[7:0];
        w_cc       = 8'h00 - r_csum;
        w_finish   = (r_rem == '0) && r_eof_sent;
        w_new_rec  = ((r_state == S_IDLE) && start) ||
                     ((r_state == S_LF) && bus.tx_ready && !w_finish);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_addr     <= '0;
            r_rec_len  <= '0;
            r_rec_cnt  <= '0;
            r_rec_addr <= '0;
            r_csum     <= '0;
            r_lo       <= '0;
            r_type     <= 1'b0;
            r_eof_sent <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy     <= 1'b1;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= 8'h3A;
                    r_state    <= S_COLON;
                end
                S_COLON:  if (bus.tx_ready) begin r_state <= S_LEN_H;  r_tx_data <= hex(r_rec_len[7:4]);    end
                S_LEN_H:  if (bus.tx_ready) begin r_state <= S_LEN_L;  r_tx_data <= hex(r_rec_len[3:0]);    end
                S_LEN_L:  if (bus.tx_ready) begin r_state <= S_ADDR3;  r_tx_data <= hex(r_rec_addr[15:12]); end
                S_ADDR3:  if (bus.tx_ready) begin r_state <= S_ADDR2;  r_tx_data <= hex(r_rec_addr[11:8]);  end
                S_ADDR2:  if (bus.tx_ready) begin r_state <= S_ADDR1;  r_tx_data <= hex(r_rec_addr[7:4]);   end
                S_ADDR1:  if (bus.tx_ready) begin r_state <= S_ADDR0;  r_tx_data <= hex(r_rec_addr[3:0]);   end
                S_ADDR0:  if (bus.tx_ready) begin r_state <= S_TYPE_H; r_tx_data <= 8'h30;                  end
                S_TYPE_H: if (bus.tx_ready) begin r_state <= S_TYPE_L; r_tx_data <= hex({3'b000, r_type});  end
                S_TYPE_L, S_DATA_L: if (bus.tx_ready) begin
                    if (r_rec_cnt != '0) begin
                        r_state    <= S_FETCH;
                        r_tx_valid <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_addr[ADDR_W-1:0];
                    end else begin
                        r_state   <= S_CSUM_H;
                        r_tx_data <= hex(w_cc[7:4]);
                    end
                end
                S_FETCH: begin
                    r_mem_rd  <= 1'b0;
                    r_addr    <= r_addr + 1'b1;
                    r_rec_cnt <= r_rec_cnt - 8'd1;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_lo       <= bus.mem_data[3:0];
                    r_csum     <= r_csum + bus.mem_data;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= hex(bus.mem_data[7:4]);
                    r_state    <= S_DATA_H;
                end
                S_DATA_H: if (bus.tx_ready) begin r_state <= S_DATA_L; r_tx_data <= hex(r_lo);        end
                S_CSUM_H: if (bus.tx_ready) begin r_state <= S_CSUM_L; r_tx_data <= hex(w_cc[3:0]);  end
                S_CSUM_L: if (bus.tx_ready) begin r_state <= S_CR;     r_tx_data <= 8'h0D;            end
                S_CR:     if (bus.tx_ready) begin r_state <= S_LF;     r_tx_data <= 8'h0A;            end
                S_LF: if (bus.tx_ready) begin
                    if (w_finish) begin
                        r_state    <= S_DONE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state   <= S_COLON;
                        r_tx_data <= 8'h3A;
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_eof_sent <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_new_rec) begin
                if (w_src_rem != '0) begin
                    r_rec_len  <= w_ll;
                    r_rec_cnt  <= w_ll;
                    r_rec_addr <= w_addr16;
                    r_type     <= 1'b0;
                    r_csum     <= w_hdr_sum;
                    r_rem      <= w_src_rem - (ADDR_W+1)'(w_ll);
                    r_addr     <= w_src_addr;
                end else begin
                    // EOF record: LL=00, AAAA=0000, TT=01, so the running sum starts at 1.
                    r_rec_len  <= '0;
                    r_rec_cnt  <= '0;
                    r_rec_addr <= '0;
                    r_type     <= 1'b1;
                    r_csum     <= 8'h01;
                    r_rem      <= '0;
                    r_eof_sent <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign busy         = r_busy;
    assign done         = r_done;
endmodule

// File: tb/tb_ihex_encoder.sv
// Bench for ihex_encoder: table of dumps with expected HEX text, plus reset corner sequences.
module tb_ihex_encoder;
    localparam int ADDR_W = 15;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            start;
    logic [ADDR_W:0] length;
    logic            busy;
    logic            done;

    ihex_encoder_if #(.ADDR_W(ADDR_W)) bus();

    ihex_encoder #(.ADDR_W(ADDR_W), .REC_LEN(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (start),
        .length  (length),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge clk_sys) if (bus.mem_rd) bus.mem_data <= rom[bus.mem_addr];

    typedef struct {
        int    len;
        bit    rnd;
        int    restart_at;
        int    alt_len;
        int    n_rd;
        string exp;
    } vec_t;

    vec_t  vecs[6];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic string show(input string s);
        string o;
        o = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      o = {o, "<CR>"};
            else if (s[i] == 8'h0A) o = {o, "<LF>"};
            else                    o = {o, $sformatf("%c", s[i])};
        end
        return o;
    endfunction

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, show(act), show(exp));
        end
    endtask

    task automatic run_dump(input int len, input bit rnd, input int restart_at, input int alt_len,
                            output string s, output int n_done, output int n_rd, output int n_bad,
                            output logic busy_at_done, output bit first_ok, output bit timed_out);
        int         post;
        bit         pend;
        logic [7:0] pd;
        s = ""; n_done = 0; n_rd = 0; n_bad = 0; busy_at_done = 1'b1;
        post = -1; pend = 1'b0; pd = '0; timed_out = 1'b1;
        @(negedge clk_sys);
        start = 1'b1; length = len[ADDR_W:0]; bus.tx_ready = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        first_ok = (bus.tx_valid === 1'b1) && (bus.tx_data === 8'h3A) && (busy === 1'b1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pend && !(bus.tx_valid === 1'b1 && bus.tx_data === pd)) n_bad++;
            if (bus.mem_rd === 1'b1) begin
                n_rd++;
                if (bus.tx_valid !== 1'b0) n_bad++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (post < 0) begin busy_at_done = busy; post = 4; end
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) length = alt_len[ADDR_W:0];
            bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pend = (bus.tx_valid === 1'b1) && !bus.tx_ready;
            pd   = bus.tx_data;
            if (bus.tx_valid === 1'b1 && bus.tx_ready) s = {s, $sformatf("%c", bus.tx_data)};
            if (post == 0) begin timed_out = 1'b0; break; end
            if (post > 0) post--;
            @(negedge clk_sys);
        end
        start = 1'b0;
    endtask

    initial begin
        string eof_rec, rec3, rec5;
        string s;
        int    n_done, n_rd, n_bad, rd;
        logic  bad_busy;
        bit    first_ok, timed_out, hit;

        eof_rec = ":00000001FF\015\012";
        rec3    = {":030000000C945C01\015\012", eof_rec};
        rec5    = {":050000000C945C1234B9\015\012", eof_rec};
        vecs[0] = '{3,  1'b0, -1, 0, 3,  rec3};
        vecs[1] = '{0,  1'b0, -1, 0, 0,  eof_rec};
        vecs[2] = '{17, 1'b0, -1, 0, 17, {":100000000C945C1234", "0000000000000000000000", "AE\015\012",
                                          ":01001000AA45\015\012", eof_rec}};
        vecs[3] = '{5,  1'b1, -1, 0, 5,  rec5};
        vecs[4] = '{5,  1'b0, -1, 0, 5,  rec5};
        vecs[5] = '{3,  1'b0, 15, 5, 3,  rec3};

        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'h00;
        rom[0] = 8'h0C; rom[1] = 8'h94; rom[2] = 8'h5C; rom[3] = 8'h12; rom[4] = 8'h34; rom[16] = 8'hAA;

        reset = 1'b1; start = 1'b0; length = '0; bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data",  bus.tx_data,  0);
        check("rst_mem_rd",   bus.mem_rd,   0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_busy",     busy,         0);
        check("rst_done",     done,         0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_dump(vecs[i].len, vecs[i].rnd, vecs[i].restart_at, vecs[i].alt_len,
                     s, n_done, n_rd, n_bad, bad_busy, first_ok, timed_out);
            check($sformatf("v%0d_timeout", i), timed_out, 0);
            check($sformatf("v%0d_first_colon", i), first_ok, 1);
            check_str($sformatf("v%0d_stream", i), s, vecs[i].exp);
            check($sformatf("v%0d_done_pulses", i), n_done, 1);
            check($sformatf("v%0d_busy_at_done", i), bad_busy, 0);
            check($sformatf("v%0d_mem_reads", i), n_rd, vecs[i].n_rd);
            check($sformatf("v%0d_protocol", i), n_bad, 0);
        end

        // Reset during the second data byte, then a clean re-dump.
        @(negedge clk_sys);
        start = 1'b1; length = 16'd5; bus.tx_ready = 1'b1;
        @(negedge clk_sys);
        start = 1'b0; rd = 0; hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.mem_rd === 1'b1) rd++;
            if (rd == 2) begin hit = 1'b1; break; end
            @(negedge clk_sys);
        end
        check("midrst_reach_byte2", hit, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_busy",     busy,         0);
        check("midrst_mem_rd",   bus.mem_rd,   0);
        check("midrst_tx_data",  bus.tx_data,  0);
        reset = 1'b0;
        run_dump(5, 1'b0, -1, 0, s, n_done, n_rd, n_bad, bad_busy, first_ok, timed_out);
        check("redump_timeout", timed_out, 0);
        check_str("redump_stream", s, rec5);
        check("redump_done_pulses", n_done, 1);

        // Reset and start together: reset wins.
        @(negedge clk_sys);
        reset = 1'b1; start = 1'b1; length = 16'd3;
        @(negedge clk_sys);
        check("rststart_busy",     busy,         0);
        check("rststart_tx_valid", bus.tx_valid, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk_sys);
        check("rststart_busy_after",     busy,         0);
        check("rststart_tx_valid_after", bus.tx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ihex_encoder.md
# ihex_encoder

Serialises a region of the cartridge ROM back out as Intel HEX ASCII text, one character per valid/ready beat, so a loaded program can be dumped over the UART or saved to the HPS. It is the transmit-side counterpart of the `clk_sys`-domain HEX parser that fills the ROM on download. It reads ROM bytes through a one-cycle-latency read port, formats data records (type 00) followed by one EOF record (type 01), and computes the checksum of each record on the fly.

## Interface
- `ADDR_W`, 15: byte address width. ROM is 2^ADDR_W bytes.
- `REC_LEN`, 16: maximum data bytes per record, legal range 1..255.

- `clk_sys` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a dump. Sampled only in IDLE.
- `length` in ADDR_W+1: byte count to dump, starting at address 0. Latched on accepted `start`. Values above 2^ADDR_W saturate to 2^ADDR_W.
- `mem_rd` out 1: ROM read strobe.
- `mem_addr` out ADDR_W: byte address for the read.
- `mem_data` in 8: ROM byte, valid exactly one cycle after `mem_rd`.
- `tx_data` out 8: ASCII character.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts. A beat transfers when `tx_valid && tx_ready`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse on the cycle after the final LF transfers.

## Operation
- Output stream for each record: `:` LL AAAA TT {DD…} CC CR(0x0D) LF(0x0A).
  - All fields are uppercase hex, high nibble first.
  - AAAA is the 16-bit byte address of the record's first byte, zero-extended.
  - TT=00 for data records.
  - LL = min(REC_LEN, remaining bytes).
- Checksum: CC = (0x100 − (LL + AAAA[15:8] + AAAA[7:0] + TT + ΣDD)) mod 256. Use an 8-bit accumulator that wraps.
- After the last data record, emit the EOF record `:00000001FF` CR LF.
- With `length`=0, emit the EOF record only.
- States: IDLE → COLON → LEN_H → LEN_L → ADDR3..ADDR0 → TYPE_H → TYPE_L, then:
  - if bytes remain in the record: FETCH → WAIT → DATA_H → DATA_L → back to FETCH or to CSUM_H;
  - otherwise CSUM_H → CSUM_L → CR → LF.
  - After LF: next record's COLON if data remains, EOF record if the data is exhausted and EOF has not been sent, else DONE → IDLE.
- Character states hold `tx_valid`=1. They advance only on transfer.
- FETCH asserts `mem_rd` for exactly one cycle with `mem_addr` = current byte address. WAIT captures `mem_data` into the byte register and adds it to the checksum.
- Nibble→ASCII mapping: 0–9 → 0x30–0x39, A–F → 0x41–0x46.
- Address counter increments per data byte. A dump of 2^ADDR_W bytes ends at address 2^ADDR_W−1 without wrap.
- `start` while `busy` is ignored. `length` is not re-sampled.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `mem_rd`=0, `mem_addr`=0, `busy`=0, `done`=0, state IDLE, checksum 0.
- `start` accepted in cycle N: `busy`=1 and `tx_valid`=1 with `:` in cycle N+1.
- With `tx_ready` held high:
  - one character per cycle in character states;
  - each data byte costs 4 cycles (FETCH, WAIT, DATA_H, DATA_L);
  - `tx_valid` is 0 during FETCH and WAIT.
- While `tx_valid && !tx_ready`, `tx_data` holds stable and no state advances.
- `done` pulses in the cycle after the EOF LF transfers. `busy` falls in that same cycle.
- `reset` mid-dump: all outputs return to reset values on the next edge. There is no resume, and a new `start` re-dumps from address 0.
- `reset` and `start` asserted in the same cycle: reset wins.

## Test plan
- ROM[0..2]=0C,94,5C, `length`=3, `tx_ready`=1 → stream `:030000000C945C01\r\n:00000001FF\r\n`. `done` pulses once and `busy` falls in the same cycle.
- `length`=0 → exactly `:00000001FF\r\n`. `mem_rd` is never asserted.
- `length`=17, ROM[16]=AA, REC_LEN=16 → first record has LL=10 and address 0000. The second record is `:01001000AA45\r\n`, followed by EOF.
- `length`=5 with `tx_ready` driven random (~50%) → character stream identical to the `tx_ready`=1 run. `tx_data` is unchanged across every stalled cycle.
- Assert `reset` during the second data byte of a record → next cycle `tx_valid`=0 and `busy`=0. A following `start` yields the full correct stream from `:`.
- Pulse `start` again mid-dump with a different `length` → output unaffected. Only one `done` pulse occurs.
